// File: rtl/io_arbiter_if.sv
// io_arbiter_if: device request/load and memory port bundle shared by io_arbiter and its users
interface io_arbiter_if #(parameter int NDEV = 2, parameter int AW = 12, parameter int DW = 30);
  logic [NDEV-1:0] dev_request;
  logic [NDEV*AW-1:0] dev_address;
  logic [NDEV-1:0] dev_write;
  logic [NDEV*DW-1:0] dev_wdata;
  logic [NDEV-1:0] dev_load;
  logic [DW-1:0] dev_data;
  logic [AW-1:0] mem_address;
  logic mem_en;
  logic mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic cpu_hold;
  logic busy;
  modport master (
    input dev_request, dev_address, dev_write, dev_wdata, mem_rdata, cpu_hold,
    output dev_load, dev_data, mem_address, mem_en, mem_we, mem_wdata, busy
  );
  modport slave (
    output dev_request, dev_address, dev_write, dev_wdata, mem_rdata, cpu_hold,
    input dev_load, dev_data, mem_address, mem_en, mem_we, mem_wdata, busy
  );
endinterface

// File: rtl/io_arbiter.sv
// io_arbiter: round-robin sharing of one synchronous memory port among NDEV devices, with CPU hold
module io_arbiter #(
  parameter int NDEV = 2,
  parameter int AW = 12,
  parameter int DW = 30
) (
  input logic clk,
  input logic reset,
  io_arbiter_if.master bus
);
  localparam int LW = $clog2(NDEV);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t st_q, st_d;
  logic [NDEV-1:0] pend_q, pend_d, load_q, load_d, we_q, we_d, cand;
  logic [NDEV-1:0][AW-1:0] addr_q, addr_d, ain;
  logic [NDEV-1:0][DW-1:0] wd_q, wd_d, win;
  logic [LW-1:0] last_q, last_d, w;
  logic found, grant;
  logic [AW-1:0] maddr_q, maddr_d;
  logic men_q, men_d, mwe_q, mwe_d, busy_q, busy_d;
  logic [DW-1:0] mwd_q, mwd_d, data_q, data_d;
  assign ain = bus.dev_address;
  assign win = bus.dev_wdata;
  always_comb begin
    cand = pend_q | bus.dev_request;
    found = 1'b0;
    w = last_q;
    for (int k = NDEV; k >= 1; k--) begin
      if (cand[(int'(last_q) + k) % NDEV]) begin
        found = 1'b1;
        w = LW'((int'(last_q) + k) % NDEV);
      end
    end
    grant = found && !bus.cpu_hold && st_q != ISSUE;
    st_d = st_q == ISSUE ? WAIT : grant ? ISSUE : IDLE;
    pend_d = cand & ~(grant ? NDEV'(1) << w : '0);
    for (int i = 0; i < NDEV; i++) begin
      addr_d[i] = bus.dev_request[i] && !pend_q[i] ? ain[i] : addr_q[i];
      we_d[i] = bus.dev_request[i] && !pend_q[i] ? bus.dev_write[i] : we_q[i];
      wd_d[i] = bus.dev_request[i] && !pend_q[i] ? win[i] : wd_q[i];
    end
    last_d = grant ? w : last_q;
    men_d = grant;
    maddr_d = grant ? (pend_q[w] ? addr_q[w] : ain[w]) : maddr_q;
    mwe_d = grant ? (pend_q[w] ? we_q[w] : bus.dev_write[w]) : mwe_q;
    mwd_d = grant ? (pend_q[w] ? wd_q[w] : win[w]) : mwd_q;
    load_d = st_q == WAIT ? NDEV'(1) << last_q : '0;
    data_d = st_q == WAIT && !mwe_q ? bus.mem_rdata : data_q;
    busy_d = st_d != IDLE;
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      st_q <= IDLE;
      pend_q <= '0;
      addr_q <= '0;
      we_q <= '0;
      wd_q <= '0;
      last_q <= LW'(NDEV - 1);
      men_q <= 1'b0;
      maddr_q <= '0;
      mwe_q <= 1'b0;
      mwd_q <= '0;
      load_q <= '0;
      data_q <= '0;
      busy_q <= 1'b0;
    end else begin
      st_q <= st_d;
      pend_q <= pend_d;
      addr_q <= addr_d;
      we_q <= we_d;
      wd_q <= wd_d;
      last_q <= last_d;
      men_q <= men_d;
      maddr_q <= maddr_d;
      mwe_q <= mwe_d;
      mwd_q <= mwd_d;
      load_q <= load_d;
      data_q <= data_d;
      busy_q <= busy_d;
    end
  end
  assign bus.mem_en = men_q;
  assign bus.mem_address = maddr_q;
  assign bus.mem_we = mwe_q;
  assign bus.mem_wdata = mwd_q;
  assign bus.dev_load = load_q;
  assign bus.dev_data = data_q;
  assign bus.busy = busy_q;
endmodule

// File: tb/tb_io_arbiter.sv
// tb_io_arbiter: table-driven and directed checks of io_arbiter against a synchronous memory model
module tb_io_arbiter;
  logic clk, reset;
  int checks = 0, errors = 0;
  logic [29:0] mem [0:4095];
  io_arbiter_if #(.NDEV(2), .AW(12), .DW(30)) bus();
  io_arbiter #(.NDEV(2), .AW(12), .DW(30)) dut (.clk(clk), .reset(reset), .bus(bus));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_address] <= bus.mem_wdata;
      bus.mem_rdata <= mem[bus.mem_address];
    end
  end
  typedef struct {
    logic rn;
    logic [1:0] req, wr;
    logic [11:0] a0, a1;
    logic [29:0] wd;
    logic hold;
    logic en, we;
    logic [11:0] ma;
    logic [1:0] ld;
    logic cd;
    logic [29:0] dat;
    logic bz;
  } vec_t;
  vec_t v [21];
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic [1:0] req, input logic [1:0] wr, input logic [11:0] a0, input logic [11:0] a1, input logic [29:0] wd, input logic hold);
    bus.dev_request = req;
    bus.dev_write = wr;
    bus.dev_address = {a1, a0};
    bus.dev_wdata = {wd, 30'd0};
    bus.cpu_hold = hold;
  endtask
  initial begin
    int n_en, n_ld0, n_ld1;
    for (int i = 0; i < 4096; i++) mem[i] = 30'd0;
    mem[8] = 30'o0102030405;
    mem[50] = 30'o3132333435;
    bus.mem_rdata = 30'd0;
    v[0]  = '{1'b1, 2'b01, 2'b00, 12'd8, 12'd0,  30'd0, 1'b0, 1'b1, 1'b0, 12'd8,  2'b00, 1'b0, 30'd0, 1'b1};
    v[1]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[2]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b01, 1'b1, 30'o0102030405, 1'b0};
    v[3]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b0};
    v[4]  = '{1'b0, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b1, 30'd0, 1'b0};
    v[5]  = '{1'b1, 2'b11, 2'b00, 12'd8, 12'd50, 30'd0, 1'b0, 1'b1, 1'b0, 12'd8,  2'b00, 1'b0, 30'd0, 1'b1};
    v[6]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[7]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b1, 1'b0, 12'd50, 2'b01, 1'b1, 30'o0102030405, 1'b1};
    v[8]  = '{1'b1, 2'b01, 2'b00, 12'd8, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[9]  = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b1, 1'b0, 12'd8,  2'b10, 1'b1, 30'o3132333435, 1'b1};
    v[10] = '{1'b1, 2'b10, 2'b00, 12'd0, 12'd50, 30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[11] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b1, 1'b0, 12'd50, 2'b01, 1'b1, 30'o0102030405, 1'b1};
    v[12] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[13] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b10, 1'b1, 30'o3132333435, 1'b0};
    v[14] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b0};
    v[15] = '{1'b1, 2'b10, 2'b10, 12'd0, 12'd52, 30'o3637303132, 1'b0, 1'b1, 1'b1, 12'd52, 2'b00, 1'b0, 30'o3637303132, 1'b1};
    v[16] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[17] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b10, 1'b0, 30'd0, 1'b0};
    v[18] = '{1'b1, 2'b10, 2'b00, 12'd0, 12'd52, 30'd0, 1'b0, 1'b1, 1'b0, 12'd52, 2'b00, 1'b0, 30'd0, 1'b1};
    v[19] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b00, 1'b0, 30'd0, 1'b1};
    v[20] = '{1'b1, 2'b00, 2'b00, 12'd0, 12'd0,  30'd0, 1'b0, 1'b0, 1'b0, 12'd0,  2'b10, 1'b1, 30'o3637303132, 1'b0};
    reset = 1'b0;
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b0);
    step();
    step();
    chk("reset en", 32'(bus.mem_en), 32'd0);
    chk("reset busy", 32'(bus.busy), 32'd0);
    chk("reset load", 32'(bus.dev_load), 32'd0);
    chk("reset data", 32'(bus.dev_data), 32'd0);
    reset = 1'b1;
    for (int i = 0; i < 21; i++) begin
      reset = v[i].rn;
      drive(v[i].req, v[i].wr, v[i].a0, v[i].a1, v[i].wd, v[i].hold);
      step();
      chk($sformatf("v%0d mem_en", i), 32'(bus.mem_en), 32'(v[i].en));
      chk($sformatf("v%0d dev_load", i), 32'(bus.dev_load), 32'(v[i].ld));
      chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'(v[i].bz));
      if (v[i].en) begin
        chk($sformatf("v%0d mem_address", i), 32'(bus.mem_address), 32'(v[i].ma));
        chk($sformatf("v%0d mem_we", i), 32'(bus.mem_we), 32'(v[i].we));
      end
      if (v[i].en && v[i].we) chk($sformatf("v%0d mem_wdata", i), 32'(bus.mem_wdata), 32'(v[i].dat));
      if (v[i].cd) chk($sformatf("v%0d dev_data", i), 32'(bus.dev_data), 32'(v[i].dat));
    end
    reset = 1'b1;
    drive(2'b01, 2'b00, 12'd8, 12'd0, 30'd0, 1'b1);
    step();
    chk("hold en first", 32'(bus.mem_en), 32'd0);
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("hold en %0d", i), 32'(bus.mem_en), 32'd0);
      chk($sformatf("hold busy %0d", i), 32'(bus.busy), 32'd0);
    end
    chk("hold pending0", 32'(dut.pend_q[0]), 32'd1);
    bus.cpu_hold = 1'b0;
    step();
    chk("release en", 32'(bus.mem_en), 32'd1);
    chk("release addr", 32'(bus.mem_address), 32'd8);
    step();
    chk("release load early", 32'(bus.dev_load), 32'd0);
    step();
    chk("release load", 32'(bus.dev_load), 32'b01);
    chk("release data", 32'(bus.dev_data), 32'o0102030405);
    step();
    drive(2'b10, 2'b00, 12'd0, 12'd50, 30'd0, 1'b0);
    step();
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b0);
    step();
    chk("rst pre busy", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    step();
    reset = 1'b1;
    chk("rst en", 32'(bus.mem_en), 32'd0);
    chk("rst we", 32'(bus.mem_we), 32'd0);
    chk("rst addr", 32'(bus.mem_address), 32'd0);
    chk("rst wdata", 32'(bus.mem_wdata), 32'd0);
    chk("rst load", 32'(bus.dev_load), 32'd0);
    chk("rst data", 32'(bus.dev_data), 32'd0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    n_ld1 = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      n_ld1 += int'(bus.dev_load != 2'b00);
    end
    chk("rst no load", 32'(n_ld1), 32'd0);
    drive(2'b11, 2'b00, 12'd8, 12'd50, 30'd0, 1'b0);
    step();
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b0);
    chk("post rst en", 32'(bus.mem_en), 32'd1);
    chk("post rst first dev0", 32'(bus.mem_address), 32'd8);
    repeat (6) step();
    drive(2'b01, 2'b00, 12'd8, 12'd0, 30'd0, 1'b1);
    step();
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b1);
    step();
    drive(2'b01, 2'b00, 12'd8, 12'd0, 30'd0, 1'b1);
    step();
    drive(2'b00, 2'b00, 12'd0, 12'd0, 30'd0, 1'b0);
    n_en = 0;
    n_ld0 = 0;
    n_ld1 = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      n_en += int'(bus.mem_en);
      n_ld0 += int'(bus.dev_load[0]);
      n_ld1 += int'(bus.dev_load[1]);
    end
    chk("dup accesses", 32'(n_en), 32'd1);
    chk("dup loads0", 32'(n_ld0), 32'd1);
    chk("dup loads1", 32'(n_ld1), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
